add_csa_pipe: RTL and testbench
===============================

ADD_CSA_PIPE -- requirements
Module: add_csa_pipe

Interface
REQ-001 Parameter WIDTH, default 25: operand/result width in bits, legal range 4..64.
REQ-002 Parameter BLK, default 8: carry-select block width in bits; the last block takes the remainder.
REQ-003 Parameter STAGES, default 2: pipeline register stages, legal range 1..4; this equals the latency in cycles.
REQ-004 clk  in  1  Single clock; all state updates on the rising edge.
REQ-005 rst  in  1  Asynchronous, active-high reset.
REQ-006 in_valid  in  1  Operand beat present.
REQ-007 in_ready  out  1  Block accepts the beat this cycle.
REQ-008 a, b  in  WIDTH each  Unsigned operands.
REQ-009 op  in  2  Operation: 00 ADD (a+b), 01 SUB (a-b), 10 ABS (|a-b|), 11 reserved and treated as ADD.
REQ-010 out_valid  out  1  Result beat present.
REQ-011 out_ready  in  1  Downstream accepts the beat.
REQ-012 s  out  WIDTH  Result.
REQ-013 co  out  1  ADD: carry-out; SUB/ABS: 1 = no borrow (a>=b).
REQ-014 swap  out  1  ABS only: 1 when b>a, so the result is b-a; 0 for all other ops.
REQ-015 zero  out  1  s == 0.

Function
REQ-016 SUB and ABS shall compute a + ~b + 1 through the carry-select chain; there is no separate subtractor.
REQ-017 Each BLK slice shall compute sum/carry for carry-in 0 and carry-in 1, then select by the incoming block carry.
REQ-018 Block carries shall be registered at stage boundaries; blocks shall be distributed over STAGES as evenly as possible, with early stages no smaller.
REQ-019 ABS with borrow (co=0) shall output the two's complement of the raw difference (= b-a) in the final stage, with swap=1 and co=0.
REQ-020 ABS with a==b shall give s=0, co=1, swap=0, zero=1.
REQ-021 A beat is accepted when in_valid && in_ready; a beat is delivered when out_valid && out_ready.
REQ-022 Pipeline advance enable: adv = out_ready || !out_valid; in_ready = adv (no combinational path from in_valid).
REQ-023 While adv=0, all stage registers and outputs shall hold; s/co/swap/zero stay stable while out_valid && !out_ready.
REQ-024 Each stage carries its own valid bit; bubbles propagate as invalid, and a result appears exactly STAGES advancing cycles after acceptance.
REQ-025 Sustained throughput shall be 1 beat/cycle with out_ready held high; beats shall never be dropped, duplicated or reordered.
REQ-026 Outputs are don't-care when out_valid=0 but shall not be X after reset.
REQ-027 Carries beyond bit WIDTH-1 are discarded except the one reported on co.

Reset
REQ-028 rst=1 shall clear all stage valid bits immediately, giving out_valid=0 and in_ready=1 with s=0, co=0, swap=0, zero=0 held for the duration of reset.
REQ-029 Reset mid-operation shall discard all in-flight beats; the first beat accepted after reset release is the first beat delivered.

Structure
REQ-030 The shared package add_csa_pkg shall hold the op encodings (OP_ADD, OP_SUB, OP_ABS) and a function returning the block count for WIDTH/BLK.
REQ-031 The sub-module csa_blk shall be a parametrised dual-carry block of width N (inputs a, b, cin; outputs s, cout), purely combinational; add_csa_pipe instantiates it per block.
REQ-032 The parameter legality checks of REQ-001 and REQ-003 shall be elaboration-time assertions.

Verification
REQ-033 ADD, WIDTH=25: a=0x1FFFFFF, b=0x0000001 -> s=0x0000000, co=1, zero=1, after exactly STAGES cycles.
REQ-034 SUB: a=5, b=3 -> s=2, co=1; a=3, b=5 -> s=0x1FFFFFE, co=0, swap=0.
REQ-035 ABS: a=3, b=5 -> s=2, co=0, swap=1; a=b=0x0ABCDEF -> s=0, co=1, zero=1, swap=0.
REQ-036 Backpressure: fill the pipeline, hold out_ready=0 for 3 cycles -> in_ready=0, outputs stable; on release the beats emerge in order with none lost.
REQ-037 Streaming: 100 random beats back-to-back for STAGES=1..4 and BLK in {4,8,WIDTH} -> results match the golden model at 1 beat/cycle.
REQ-038 Assert rst with 2 beats in flight -> out_valid=0 next cycle; the next accepted beat's result is the first delivered.

Source files
------------

// File: rtl/add_csa_pkg.sv
// Shared op encodings and block/stage partitioning helpers for the carry-select pipeline.
package add_csa_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ABS = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  function automatic int unsigned num_blocks(int unsigned width, int unsigned blk);
    return (width + blk - 1) / blk;
  endfunction

  // Early stages take the extra block when blocks do not divide evenly.
  function automatic int unsigned stage_blocks(int unsigned nb, int unsigned stages, int unsigned k);
    return nb / stages + ((k < nb % stages) ? 1 : 0);
  endfunction

  function automatic int unsigned stage_first(int unsigned nb, int unsigned stages, int unsigned k);
    int unsigned acc;
    acc = 0;
    for (int unsigned i = 0; i < k; i++) acc += stage_blocks(nb, stages, i);
    return acc;
  endfunction

  function automatic int unsigned block_stage(int unsigned nb, int unsigned stages, int unsigned j);
    int unsigned k;
    k = 0;
    for (int unsigned i = 0; i < stages; i++) begin
      if (j >= stage_first(nb, stages, i)) k = i;
    end
    return k;
  endfunction

endpackage

// File: rtl/csa_blk.sv
// Dual-carry adder slice: sums for both carry-in values, selected by the incoming carry.
module csa_blk #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout
);

  logic [N:0] r0;
  logic [N:0] r1;

  assign r0   = {1'b0, a} + {1'b0, b};
  assign r1   = {1'b0, a} + {1'b0, b} + (N+1)'(1);
  assign s    = cin ? r1[N-1:0] : r0[N-1:0];
  assign cout = cin ? r1[N] : r0[N];

endmodule

// File: rtl/add_csa_pipe.sv
// Pipelined carry-select add/sub/abs unit with valid/ready flow control.
module add_csa_pipe
  import add_csa_pkg::*;
#(
  parameter int unsigned WIDTH  = 25,
  parameter int unsigned BLK    = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             swap,
  output logic             zero
);

  localparam int unsigned NB = num_blocks(WIDTH, BLK);
  localparam int unsigned IM = (STAGES > 1) ? STAGES - 1 : 1;

  if (WIDTH < 4 || WIDTH > 64) begin : g_bad_width
    $error("add_csa_pipe: WIDTH must be in 4..64");
  end
  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("add_csa_pipe: STAGES must be in 1..4");
  end
  if (BLK < 1 || BLK > WIDTH) begin : g_bad_blk
    $error("add_csa_pipe: BLK must be in 1..WIDTH");
  end

  logic adv;

  logic [WIDTH-1:0] st_a   [STAGES];
  logic [WIDTH-1:0] st_b   [STAGES];
  logic [WIDTH-1:0] st_sum [STAGES];
  logic             st_c   [STAGES];
  logic             st_v   [STAGES];
  logic [1:0]       st_op  [STAGES];

  logic [WIDTH-1:0] a_q   [IM];
  logic [WIDTH-1:0] b_q   [IM];
  logic [WIDTH-1:0] sum_q [IM];
  logic             c_q   [IM];
  logic             v_q   [IM];
  logic [1:0]       op_q  [IM];

  logic [WIDTH-1:0] blk_s;
  logic             blk_ci  [NB];
  logic             blk_co  [NB];
  logic             stg_co  [STAGES];
  logic [WIDTH-1:0] stg_sum [STAGES];

  logic [WIDTH-1:0] s_d, s_q;
  logic             co_d, co_q, swap_d, swap_q, zero_d, zero_q, valid_q;
  logic             sub;

  assign adv      = out_ready || !valid_q;
  assign in_ready = adv;

  // Stage inputs: stage 0 from the ports (b inverted, carry-in set for SUB/ABS), later stages from registers.
  always_comb begin
    sub        = (op == OP_SUB) || (op == OP_ABS);
    st_v[0]    = in_valid;
    st_a[0]    = a;
    st_b[0]    = sub ? ~b : b;
    st_c[0]    = sub;
    st_op[0]   = op;
    st_sum[0]  = '0;
    for (int k = 1; k < int'(STAGES); k++) begin
      st_v[k]   = v_q[k-1];
      st_a[k]   = a_q[k-1];
      st_b[k]   = b_q[k-1];
      st_c[k]   = c_q[k-1];
      st_op[k]  = op_q[k-1];
      st_sum[k] = sum_q[k-1];
    end
  end

  for (genvar j = 0; j < int'(NB); j++) begin : g_blk
    localparam int unsigned LO = j * BLK;
    localparam int unsigned BW = (j == int'(NB) - 1) ? WIDTH - LO : BLK;
    localparam int unsigned SG = block_stage(NB, STAGES, j);

    if (j == int'(stage_first(NB, STAGES, SG))) begin : g_head
      assign blk_ci[j] = st_c[SG];
    end else begin : g_chain
      assign blk_ci[j] = blk_co[j-1];
    end

    csa_blk #(.N(BW)) u_blk (
      .a    (st_a[SG][LO +: BW]),
      .b    (st_b[SG][LO +: BW]),
      .cin  (blk_ci[j]),
      .s    (blk_s[LO +: BW]),
      .cout (blk_co[j])
    );
  end

  for (genvar k = 0; k < int'(STAGES); k++) begin : g_stg
    localparam int unsigned CNT   = stage_blocks(NB, STAGES, k);
    localparam int unsigned FIRST = stage_first(NB, STAGES, k);

    if (CNT == 0) begin : g_pass
      assign stg_co[k]  = st_c[k];
      assign stg_sum[k] = st_sum[k];
    end else begin : g_work
      localparam int unsigned LO = FIRST * BLK;
      localparam int unsigned HI = (FIRST + CNT == NB) ? WIDTH : (FIRST + CNT) * BLK;
      localparam logic [WIDTH-1:0] MASK = ({WIDTH{1'b1}} << LO) & ~({WIDTH{1'b1}} << HI);
      assign stg_co[k]  = blk_co[FIRST + CNT - 1];
      assign stg_sum[k] = (blk_s & MASK) | (st_sum[k] & ~MASK);
    end
  end

  // Final stage: ABS with borrow negates the raw difference to produce b-a.
  always_comb begin
    swap_d = (st_op[STAGES-1] == OP_ABS) && !stg_co[STAGES-1];
    co_d   = stg_co[STAGES-1];
    s_d    = swap_d ? WIDTH'(~stg_sum[STAGES-1] + 1'b1) : stg_sum[STAGES-1];
    zero_d = (s_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < int'(IM); k++) begin
        v_q[k]   <= 1'b0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        c_q[k]   <= 1'b0;
        sum_q[k] <= '0;
        op_q[k]  <= '0;
      end
      valid_q <= 1'b0;
      s_q     <= '0;
      co_q    <= 1'b0;
      swap_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < int'(STAGES) - 1; k++) begin
        v_q[k]   <= st_v[k];
        a_q[k]   <= st_a[k];
        b_q[k]   <= st_b[k];
        c_q[k]   <= stg_co[k];
        sum_q[k] <= stg_sum[k];
        op_q[k]  <= st_op[k];
      end
      valid_q <= st_v[STAGES-1];
      s_q     <= s_d;
      co_q    <= co_d;
      swap_q  <= swap_d;
      zero_q  <= zero_d;
    end
  end

  assign out_valid = valid_q;
  assign s         = s_q;
  assign co        = co_q;
  assign swap      = swap_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_add_csa_pipe.sv
// Self-checking bench: directed corners, backpressure, reset flush, random traffic and a config grid.
module tb_add_csa_pipe;

  localparam int unsigned W   = 25;
  localparam int unsigned STG = 2;
  localparam int unsigned NG  = 12;

  typedef struct packed {
    logic [W-1:0] s;
    logic         co;
    logic         swap;
    logic         zero;
  } res_t;

  typedef struct {
    res_t r;
    int   cyc;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [1:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] s;
  logic         co;
  logic         swap;
  logic         zero;

  logic         g_valid;
  logic         g_in_ready [NG];
  int           g_cnt      [NG];

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  bit lat_chk = 1'b0;

  exp_t mq[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: plain integer arithmetic on the unsigned operands.
  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic [1:0] o);
    longint unsigned ax, by, t;
    res_t r;
    ax = 64'(x);
    by = 64'(y);
    r.swap = 1'b0;
    case (o)
      2'b01: begin
        r.co = (ax >= by);
        t    = ax - by;
      end
      2'b10: begin
        if (ax >= by) begin
          r.co = 1'b1;
          t    = ax - by;
        end else begin
          r.co   = 1'b0;
          r.swap = 1'b1;
          t      = by - ax;
        end
      end
      default: begin
        t    = ax + by;
        r.co = t[W];
      end
    endcase
    r.s    = W'(t);
    r.zero = (r.s == '0);
    return r;
  endfunction

  function automatic logic [W-1:0] rnd_val();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      default: return W'($urandom);
    endcase
  endfunction

  add_csa_pipe #(.WIDTH(W), .BLK(8), .STAGES(STG)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .co        (co),
    .swap      (swap),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    exp_t e;
    if (!rst && in_valid && in_ready) begin
      e.r   = model(a, b, op);
      e.cyc = cyc;
      mq.push_back(e);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (mq.size() == 0) check("spurious_beat", 64'd1, 64'd0);
      else begin
        e = mq.pop_front();
        check("result", 64'(res_t'({s, co, swap, zero})), 64'(e.r));
        if (lat_chk) check("latency", 64'(cyc - e.cyc), 64'(STG));
      end
    end
  end

  for (genvar gi = 0; gi < int'(NG); gi++) begin : g_cfg
    localparam int unsigned GS = gi / 3 + 1;
    localparam int unsigned GB = (gi % 3 == 0) ? 4 : ((gi % 3 == 1) ? 8 : W);
    logic         ir, ov, gco, gsw, gz;
    logic [W-1:0] gs;
    exp_t         q[$];
    int           cnt = 0;

    add_csa_pipe #(.WIDTH(W), .BLK(GB), .STAGES(GS)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (g_valid),
      .in_ready  (ir),
      .a         (a),
      .b         (b),
      .op        (op),
      .out_valid (ov),
      .out_ready (1'b1),
      .s         (gs),
      .co        (gco),
      .swap      (gsw),
      .zero      (gz)
    );

    always @(posedge clk) begin
      exp_t e;
      if (!rst && g_valid && ir) begin
        e.r   = model(a, b, op);
        e.cyc = cyc;
        q.push_back(e);
      end
    end

    always @(negedge clk) begin
      exp_t e;
      if (!rst && ov) begin
        if (q.size() == 0) check($sformatf("grid%0d_spurious", gi), 64'd1, 64'd0);
        else begin
          e = q.pop_front();
          check($sformatf("grid%0d_result", gi), 64'({gs, gco, gsw, gz}), 64'(e.r));
          check($sformatf("grid%0d_latency", gi), 64'(cyc - e.cyc), 64'(GS));
          cnt++;
        end
      end
    end

    assign g_cnt[gi]      = cnt;
    assign g_in_ready[gi] = ir;
  end

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic [1:0] o);
    int t;
    t        = 0;
    a        = x;
    b        = y;
    op       = o;
    in_valid = 1'b1;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("send_timeout", 64'd0, 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Single beat into an empty pipe; output must appear exactly STG cycles later.
  task automatic send_dir(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [1:0] o, input logic [W-1:0] es, input logic eco,
                          input logic esw, input logic ez);
    a        = x;
    b        = y;
    op       = o;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 1; k < int'(STG); k++) begin
      check({tag, "_early"}, 64'(out_valid), 64'd0);
      @(negedge clk);
    end
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check(tag, 64'({s, co, swap, zero}), 64'({es, eco, esw, ez}));
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    g_valid   = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    op        = 2'b00;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_s",         64'(s),         64'd0);
    check("rst_co",        64'(co),        64'd0);
    check("rst_swap",      64'(swap),      64'd0);
    check("rst_zero",      64'(zero),      64'd0);
    rst = 1'b0;
    @(negedge clk);

    lat_chk = 1'b1;
    send_dir("add_wrap",  25'h1FFFFFF, 25'h0000001, 2'b00, 25'h0000000, 1'b1, 1'b0, 1'b1);
    send_dir("sub_pos",   25'd5,       25'd3,       2'b01, 25'd2,       1'b1, 1'b0, 1'b0);
    send_dir("sub_neg",   25'd3,       25'd5,       2'b01, 25'h1FFFFFE, 1'b0, 1'b0, 1'b0);
    send_dir("abs_swap",  25'd3,       25'd5,       2'b10, 25'd2,       1'b0, 1'b1, 1'b0);
    send_dir("abs_eq",    25'h0ABCDEF, 25'h0ABCDEF, 2'b10, 25'd0,       1'b1, 1'b0, 1'b1);
    send_dir("abs_pos",   25'd5,       25'd3,       2'b10, 25'd2,       1'b1, 1'b0, 1'b0);
    send_dir("rsv_add",   25'h1000000, 25'h1000000, 2'b11, 25'd0,       1'b1, 1'b0, 1'b1);

    // Backpressure: fill, stall three cycles, then release.
    lat_chk   = 1'b0;
    out_ready = 1'b0;
    send(rnd_val(), rnd_val(), 2'($urandom));
    send(rnd_val(), rnd_val(), 2'($urandom));
    a        = rnd_val();
    b        = rnd_val();
    op       = 2'b10;
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("bp_in_ready",  64'(in_ready),  64'd0);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      if (mq.size() > 0) check("bp_hold", 64'({s, co, swap, zero}), 64'(mq[0].r));
      else check("bp_queue", 64'd0, 64'd1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("bp_drained", 64'(mq.size()), 64'd0);

    // Random traffic with random backpressure.
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      a         = rnd_val();
      b         = ($urandom_range(0, 5) == 0) ? a : rnd_val();
      op        = 2'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (8) @(negedge clk);
    check("rand_drained", 64'(mq.size()), 64'd0);

    // Reset with two beats in flight discards them.
    in_valid = 1'b1;
    a = 25'd7;  b = 25'd9;  op = 2'b00;
    @(negedge clk);
    a = 25'd11; b = 25'd4;  op = 2'b01;
    @(negedge clk);
    in_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_in_ready",  64'(in_ready),  64'd1);
    mq.delete();
    @(negedge clk);
    @(negedge clk);
    rst     = 1'b0;
    lat_chk = 1'b1;
    @(negedge clk);
    send_dir("post_rst", 25'd100, 25'd1, 2'b01, 25'd99, 1'b1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("post_rst_drained", 64'(mq.size()), 64'd0);

    // Back-to-back streaming across the configuration grid.
    for (int i = 0; i < int'(NG); i++) check($sformatf("grid%0d_ready", i), 64'(g_in_ready[i]), 64'd1);
    g_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      a  = rnd_val();
      b  = ($urandom_range(0, 5) == 0) ? a : rnd_val();
      op = 2'($urandom);
      @(negedge clk);
    end
    g_valid = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < int'(NG); i++) check($sformatf("grid%0d_count", i), 64'(g_cnt[i]), 64'd100);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
